sine_rom_sched: RTL and testbench
=================================

Name: sine_rom_sched

Overview:
- Time-multiplexes one single-read-port synchronous sine ROM (one-cycle read latency) between two phase-accumulating channels, ch0 and ch1.
- Each channel has its own frequency increment. ch1 also has a phase offset applied to its ROM address.
- Drives the ROM address and captures the ROM data. Delivers per-channel samples with one-cycle valid strobes to the DAC/output stage.
- One sample frame per channel takes 3 clock cycles.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width; phase accumulator width.
- DATA_WIDTH, 8, ROM data / sample width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; sampled only in IDLE and CAPTURE1.
- incr0  input  ADDRESS_WIDTH  ch0 phase increment per frame.
- incr1  input  ADDRESS_WIDTH  ch1 phase increment per frame.
- offset  input  ADDRESS_WIDTH  ch1 address offset added to phase1.
- rom_addr  output  ADDRESS_WIDTH  address to ROM; combinational from state and shadow registers.
- rom_dout  input  DATA_WIDTH  ROM data; valid the cycle after rom_addr is presented.
- dout0  output  DATA_WIDTH  ch0 sample register.
- dout1  output  DATA_WIDTH  ch1 sample register.
- valid0  output  1  one-cycle strobe: dout0 updated this cycle.
- valid1  output  1  one-cycle strobe: dout1 updated this cycle.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge, regardless of state):
  - state=IDLE; phase0, phase1, and shadows incr0_s/incr1_s/offset_s = 0.
  - dout0=dout1=0, valid0=valid1=0.
  - Any capture in flight is discarded; no strobe is emitted after reset.
- FSM states: IDLE, ISSUE0, ISSUE1, CAPTURE1.
  - IDLE: rom_addr=phase0. en=1 -> ISSUE0, else stay.
  - ISSUE0: rom_addr=phase0. Latch incr0_s<=incr0, incr1_s<=incr1, offset_s<=offset. -> ISSUE1.
  - ISSUE1: rom_addr=(phase1+offset_s) mod 2^ADDRESS_WIDTH. Capture dout0<=rom_dout; valid0=1 in the next cycle. -> CAPTURE1.
  - CAPTURE1: rom_addr=(phase1+offset_s). Capture dout1<=rom_dout; valid1=1 in the next cycle.
    - Advance phase0<=phase0+incr0_s and phase1<=phase1+incr1_s, both mod 2^ADDRESS_WIDTH (wrap, no saturation).
    - en=1 -> ISSUE0, else -> IDLE.
- Strobes:
  - valid0/valid1 are registered and high for exactly one cycle per frame; they are never high simultaneously.
  - Steady state with en=1: each strobe repeats every 3 cycles.
- Shadow registers:
  - incr/offset changes take effect only at the next ISSUE0.
  - Mid-frame changes never corrupt the current frame.
- en deassert:
  - en is ignored in ISSUE0/ISSUE1; the frame in progress always completes, including both strobes.
  - Then IDLE. Phases hold their values; resume continues from the held phases.
- Latency:
  - en rising in IDLE at cycle N -> ISSUE0 at N+1 -> valid0 at N+3, valid1 at N+4.
- Edge values:
  - incr=0: constant output.
  - offset=0: ch1 reads the same address as ch0 when incr0=incr1.
  - Phase sums carry out of the MSB and are dropped.
- dout0/dout1 hold their last value between strobes and in IDLE.

Test Plan:
- Reset/idle:
  - Stimulus: rst=1 for 2 cycles, then rst=0, en=0 for 10 cycles.
  - Required: dout0=dout1=0, valid0=valid1=0, busy=0, rom_addr=0 throughout.
- First frame, sine ROM (rom[0]=0x80, rom[64]=0xFF):
  - Stimulus: incr0=incr1=1, offset=64, en rises at cycle N.
  - Required: valid0 at N+3 with dout0=0x80; valid1 at N+4 with dout1=0xFF; rom_addr=1 at N+4.
- Wrap-around:
  - Stimulus: incr0=0x90, en held.
  - Required: ch0 addresses across successive frames are 0x00, 0x90, 0x20, 0xB0.
  - Required: valid0 period is exactly 3 cycles; valid0 and valid1 are never coincident.
- Mid-frame config change:
  - Stimulus: change incr0 from 1 to 5 during ISSUE1 of frame k.
  - Required: frame k+1 address = k+1; frame k+2 address = k+6.
- en drop:
  - Stimulus: en=0 during ISSUE0.
  - Required: that frame still emits valid0 and valid1, then busy=0.
  - Required: after re-enable, the next ch0 address continues from the held phase.
- Reset mid-frame:
  - Stimulus: rst=1 during ISSUE1.
  - Required: next cycle state=IDLE, valid0=0 (the pending capture is dropped), phases=0, douts=0.

Source files
------------

// File: rtl/sine_rom_sched.sv
// ---------------------------------------------------------------------------
// sine_rom_sched
//
// Shares one synchronous sine ROM (single read port, one-cycle read latency)
// between two phase-accumulating channels. A frame is three cycles:
//   ISSUE0   : present ch0 address, snapshot incr0/incr1/offset
//   ISSUE1   : present ch1 address, capture ch0 data from the ROM
//   CAPTURE1 : capture ch1 data, advance both phase accumulators
// The frame loops straight back to ISSUE0 while en is high, so each channel
// produces one sample every three cycles.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   en        run enable, looked at only in IDLE and CAPTURE1
//   incr0     ch0 phase increment per frame
//   incr1     ch1 phase increment per frame
//   offset    ch1 address offset added to phase1
//   rom_addr  ROM address (combinational from state and held registers)
//   rom_dout  ROM read data, valid one cycle after rom_addr
//   dout0     ch0 sample register
//   dout1     ch1 sample register
//   valid0    one-cycle strobe, dout0 just updated
//   valid1    one-cycle strobe, dout1 just updated
//   busy      high whenever a frame is in progress
// ---------------------------------------------------------------------------
module sine_rom_sched #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] incr0,
    input  logic [ADDRESS_WIDTH-1:0] incr1,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout,
    output logic [DATA_WIDTH-1:0]    dout0,
    output logic [DATA_WIDTH-1:0]    dout1,
    output logic                     valid0,
    output logic                     valid1,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE0   = 2'd1,
        ISSUE1   = 2'd2,
        CAPTURE1 = 2'd3
    } state_t;

    state_t                   state_q,    state_d;
    logic [ADDRESS_WIDTH-1:0] phase0_q,   phase0_d;
    logic [ADDRESS_WIDTH-1:0] phase1_q,   phase1_d;
    logic [ADDRESS_WIDTH-1:0] incr0_s_q,  incr0_s_d;
    logic [ADDRESS_WIDTH-1:0] incr1_s_q,  incr1_s_d;
    logic [ADDRESS_WIDTH-1:0] offset_s_q, offset_s_d;
    logic [DATA_WIDTH-1:0]    dout0_q,    dout0_d;
    logic [DATA_WIDTH-1:0]    dout1_q,    dout1_d;
    logic                     valid0_q,   valid0_d;
    logic                     valid1_q,   valid1_d;
    logic [ADDRESS_WIDTH-1:0] ch1_addr_s;
    logic [ADDRESS_WIDTH-1:0] rom_addr_s;

    // Next-state, datapath and ROM address decode for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        phase0_d   = phase0_q;
        phase1_d   = phase1_q;
        incr0_s_d  = incr0_s_q;
        incr1_s_d  = incr1_s_q;
        offset_s_d = offset_s_q;
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;
        valid0_d   = 1'b0;
        valid1_d   = 1'b0;
        // Carry out of the MSB is dropped: the address wraps around the table.
        ch1_addr_s = phase1_q + offset_s_q;
        rom_addr_s = phase0_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ISSUE0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE0: begin
                // Snapshot the configuration so changes made later in the
                // frame cannot disturb it; they are picked up next frame.
                incr0_s_d  = incr0;
                incr1_s_d  = incr1;
                offset_s_d = offset;
                state_d    = ISSUE1;
            end
            ISSUE1: begin
                // ROM now returns the ch0 word addressed during ISSUE0.
                rom_addr_s = ch1_addr_s;
                dout0_d    = rom_dout;
                valid0_d   = 1'b1;
                state_d    = CAPTURE1;
            end
            CAPTURE1: begin
                rom_addr_s = ch1_addr_s;
                dout1_d    = rom_dout;
                valid1_d   = 1'b1;
                phase0_d   = phase0_q + incr0_s_q;
                phase1_d   = phase1_q + incr1_s_q;
                if (en) begin
                    state_d = ISSUE0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also drops any capture in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase0_q   <= {ADDRESS_WIDTH{1'b0}};
            phase1_q   <= {ADDRESS_WIDTH{1'b0}};
            incr0_s_q  <= {ADDRESS_WIDTH{1'b0}};
            incr1_s_q  <= {ADDRESS_WIDTH{1'b0}};
            offset_s_q <= {ADDRESS_WIDTH{1'b0}};
            dout0_q    <= {DATA_WIDTH{1'b0}};
            dout1_q    <= {DATA_WIDTH{1'b0}};
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase0_q   <= phase0_d;
            phase1_q   <= phase1_d;
            incr0_s_q  <= incr0_s_d;
            incr1_s_q  <= incr1_s_d;
            offset_s_q <= offset_s_d;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
        end
    end

    assign rom_addr = rom_addr_s;
    assign dout0    = dout0_q;
    assign dout1    = dout1_q;
    assign valid0   = valid0_q;
    assign valid1   = valid1_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sine_rom_sched.sv
// ---------------------------------------------------------------------------
// tb_sine_rom_sched
//
// Bench for sine_rom_sched. A behavioural sine ROM with one-cycle latency
// sits on the ROM port. Each run computes the expected address/sample of
// every frame from its own phase model and queues them per channel; a
// negedge monitor pops an entry on every strobe and compares the sample and
// the address that was on rom_addr two cycles earlier.
// ---------------------------------------------------------------------------
module tb_sine_rom_sched;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] incr0;
    logic [7:0] incr1;
    logic [7:0] offset;
    logic [7:0] rom_addr;
    logic [7:0] rom_dout;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic       valid0;
    logic       valid1;
    logic       busy;

    logic [7:0] rom [256];
    sb_t        exp0_q [$];
    sb_t        exp1_q [$];
    int         v0_times [$];
    int         v1_times [$];
    int         cyc;
    int         n_tests;
    int         n_fail;
    logic [7:0] m0;
    logic [7:0] m1;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [7:0] last_v1_addr;

    sine_rom_sched dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .incr0    (incr0),
        .incr1    (incr1),
        .offset   (offset),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .dout0    (dout0),
        .dout1    (dout1),
        .valid0   (valid0),
        .valid1   (valid1),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: value X during cycle X.
    always @(posedge clk) cyc = cyc + 1;

    // Synchronous ROM, one-cycle read latency.
    always @(posedge clk) rom_dout <= rom[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe monitor / scoreboard consumer.
    always @(negedge clk) begin
        sb_t e;
        if (valid0) begin
            v0_times.push_back(cyc);
            check_eq("v0_v1_coincident", 32'(valid1), 32'd0);
            if (exp0_q.size() == 0) begin
                check_eq("v0_unexpected", 32'(valid0), 32'd0);
            end else begin
                e = exp0_q.pop_front();
                check_eq("ch0_addr", 32'(h2), 32'(e.addr));
                check_eq("ch0_data", 32'(dout0), 32'(e.data));
            end
        end
        if (valid1) begin
            v1_times.push_back(cyc);
            last_v1_addr = rom_addr;
            if (exp1_q.size() == 0) begin
                check_eq("v1_unexpected", 32'(valid1), 32'd0);
            end else begin
                e = exp1_q.pop_front();
                check_eq("ch1_addr", 32'(h2), 32'(e.addr));
                check_eq("ch1_data", 32'(dout1), 32'(e.data));
            end
        end
        h2 = h1;
        h1 = rom_addr;
    end

    // Run n frames from IDLE. en is dropped during ISSUE0 of the last frame.
    // If chg >= 0, incr0 is changed to new_i0 during ISSUE1 of frame chg.
    task automatic run(input int n, input int chg, input logic [7:0] new_i0);
        int         start;
        logic [7:0] iu;
        sb_t        e;
        for (int j = 0; j < n; j++) begin
            iu     = (chg >= 0 && j > chg) ? new_i0 : incr0;
            e.addr = m0;
            e.data = rom[m0];
            exp0_q.push_back(e);
            e.addr = m1 + offset;
            e.data = rom[e.addr];
            exp1_q.push_back(e);
            m0 = m0 + iu;
            m1 = m1 + incr1;
        end
        v0_times.delete();
        v1_times.delete();
        start = cyc;
        en    = 1'b1;
        for (int c = 0; c < 3 * n; c++) begin
            tick(1);
            if (c == 3 * chg + 1) incr0 = new_i0;
            if (c == 3 * (n - 1)) en = 1'b0;
        end
        tick(2);
        @(negedge clk);
        check_eq("busy_after_run", 32'(busy), 32'd0);
        check_eq("held_phase_addr", 32'(rom_addr), 32'(m0));
        check_eq("addr_at_last_v1", 32'(last_v1_addr), 32'(m0));
        check_eq("v0_count", 32'(v0_times.size()), 32'(n));
        check_eq("v1_count", 32'(v1_times.size()), 32'(n));
        if (v0_times.size() > 0) check_eq("v0_latency", 32'(v0_times[0] - start), 32'd3);
        if (v1_times.size() > 0) check_eq("v1_latency", 32'(v1_times[0] - start), 32'd4);
        for (int j = 1; j < v0_times.size(); j++)
            check_eq("v0_period", 32'(v0_times[j] - v0_times[j-1]), 32'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        h1      = 8'd0;
        h2      = 8'd0;
        last_v1_addr = 8'd0;
        for (int a = 0; a < 256; a++)
            rom[a] = 8'(int'($floor(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * a / 256.0) + 0.5)));
        rst    = 1'b1;
        en     = 1'b0;
        incr0  = 8'd0;
        incr1  = 8'd0;
        offset = 8'd0;
        m0     = 8'd0;
        m1     = 8'd0;

        // Reset and idle.
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_dout0", 32'(dout0), 32'd0);
            check_eq("idle_dout1", 32'(dout1), 32'd0);
            check_eq("idle_valid0", 32'(valid0), 32'd0);
            check_eq("idle_valid1", 32'(valid1), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_rom_addr", 32'(rom_addr), 32'd0);
        end
        @(posedge clk);
        #1;

        // First frame: ch0 at 0 (0x80), ch1 at 64 (0xFF).
        incr0  = 8'd1;
        incr1  = 8'd1;
        offset = 8'd64;
        run(1, -1, 8'd0);
        check_eq("first_dout0", 32'(dout0), 32'h80);
        check_eq("first_dout1", 32'(dout1), 32'hFF);

        // Wrap-around from phase 0: ch0 at 0x00, 0x90, 0x20, 0xB0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m0 = 8'd0;
        m1 = 8'd0;
        incr0  = 8'h90;
        incr1  = 8'h33;
        offset = 8'h10;
        run(4, -1, 8'd0);
        check_eq("wrap_next_phase0", 32'(m0), 32'h40);

        // Mid-frame incr0 change 1 -> 5 during ISSUE1 of the first frame.
        incr0  = 8'd1;
        incr1  = 8'd2;
        offset = 8'h20;
        run(3, 0, 8'd5);

        // Idle gap, then resume from the held phases.
        tick(5);
        incr0 = 8'd7;
        run(2, -1, 8'd0);

        // Reset during ISSUE1: pending capture dropped, everything cleared.
        incr0  = 8'd3;
        incr1  = 8'd4;
        offset = 8'd9;
        en = 1'b1;
        tick(1);
        tick(1);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_mid_valid0", 32'(valid0), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_dout0", 32'(dout0), 32'd0);
        check_eq("rst_mid_dout1", 32'(dout1), 32'd0);
        check_eq("rst_mid_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m0 = 8'd0;
        m1 = 8'd0;
        tick(3);

        // Zero increments and zero offset: constant output, same address both channels.
        incr0  = 8'd0;
        incr1  = 8'd0;
        offset = 8'd0;
        run(3, -1, 8'd0);
        check_eq("const_dout0", 32'(dout0), 32'h80);
        check_eq("const_dout1", 32'(dout1), 32'h80);

        check_eq("sb0_drained", 32'(exp0_q.size()), 32'd0);
        check_eq("sb1_drained", 32'(exp1_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
